csa_bist: RTL and testbench
===========================

// Module: csa_bist
// PURPOSE
//  On-board built-in self test for the CSA(WIDTH) adder on the BASYS3 board.
//  Drives the adder's a/b/ci inputs and checks its sum/co outputs.
//  Sweeps every (a,b,ci) combination and compares {co,sum} against a+b+ci.
//  Reports pass/fail, error count and the first failing vector to LEDs/ILA.
// PARAMETERS
//  WIDTH   3  operand width of the adder under test (1..8)
//  SETTLE  2  clock cycles to hold each vector before sampling (>=1)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous active-low reset
//  start        in   1          1-cycle pulse; begins a sweep when not busy
//  a            out  WIDTH      operand A to adder under test (registered)
//  b            out  WIDTH      operand B to adder under test (registered)
//  ci           out  1          carry-in to adder under test (registered)
//  sum          in   WIDTH      adder sum result
//  co           in   1          adder carry-out
//  busy         out  1          sweep in progress
//  done         out  1          sweep finished; held until next start or reset
//  pass         out  1          valid when done: 1 iff zero mismatches
//  err_count    out  2*WIDTH+2  number of mismatching vectors in last sweep
//  fail_seen    out  1          at least one mismatch captured
//  fail_vec     out  2*WIDTH+1  {a,b,ci} of first mismatch
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; every output 0, including a/b/ci,
//    busy, done, pass, err_count, fail_seen and fail_vec.
//  - Vector counter vec[2W:0] = {a,b,ci}. a/b/ci are driven from vec fields.
//    vec increments by 1, so ci toggles fastest and a changes slowest.
//  - FSM states: IDLE, WAIT, CHECK, DONE.
//  - IDLE/DONE + start=1: clear vec, err_count, fail_seen, fail_vec, done and
//    pass. Set busy=1, load settle counter with SETTLE, go to WAIT.
//  - WAIT: decrement the settle counter. When it reaches 1, go to CHECK.
//  - CHECK: expected[W:0] = a+b+ci, computed at W+1 bits with no truncation.
//    - Mismatch if {co,sum} != expected. On a mismatch, err_count += 1.
//    - On the first mismatch only, also set fail_seen=1 and fail_vec=vec.
//  - CHECK exit when vec is all ones: go to DONE. done=1, busy=0, and
//    pass=(final err_count==0), including the last vector's result.
//  - CHECK exit otherwise: vec += 1, reload the settle counter, go to WAIT.
//  - Cost per vector: SETTLE+1 cycles. Full sweep: 2^(2W+1)*(SETTLE+1)
//    cycles, which is 384 for the defaults.
//  - start while busy: ignored, with no effect on vec or counters.
//  - err_count max is 2^(2W+1), which fits without wrap. No saturation logic.
//  - rst_n asserted mid-sweep: immediate return to IDLE with all outputs 0.
//    The next start runs a complete fresh sweep.
//  - a/b/ci stay at the last vector (all ones) in DONE until restart/reset.
// TESTING
//  1. Behavioural correct adder, WIDTH=3, SETTLE=2, start pulse:
//     -> done=1 exactly 384 cycles later; pass=1, err_count=0, fail_seen=0.
//  2. Adder model with co stuck at 0:
//     -> pass=0, err_count=64, fail_seen=1;
//     -> fail_vec={3'd0,3'd7,1'b1} (vec=15).
//  3. Adder model with sum[0] stuck at 1:
//     -> err_count=64, fail_vec=0 (first vector fails).
//  4. start re-pulsed at cycle 100 of a sweep:
//     -> ignored; done still at cycle 384 with identical results.
//  5. rst_n low for 1 cycle at cycle 200:
//     -> all outputs 0 immediately. New start -> full 384-cycle sweep, pass=1.
//  6. SETTLE=1, WIDTH=2, correct adder:
//     -> done after 2^5*2=64 cycles; pass=1. Second start after done clears
//        done the next cycle and repeats.

Source files
------------

// File: rtl/csa_bist.sv
// Built-in self test for a WIDTH-bit adder: sweeps every {a,b,ci} vector, holds each
// for SETTLE cycles, then compares {co,sum} against a+b+ci and records error statistics.
module csa_bist #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 ci,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 co,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic                 fail_seen,
  output logic [2*WIDTH:0]     fail_vec
);

  localparam int VW = 2*WIDTH + 1;
  localparam int CW = 2*WIDTH + 2;
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [CW-1:0]   err_q, err_d;
  logic            fail_seen_q, fail_seen_d;
  logic [VW-1:0]   fail_vec_q, fail_vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic [WIDTH:0]  expected;
  logic            mismatch;

  // Reference result is kept at WIDTH+1 bits so the carry-out is checked too.
  always_comb begin
    expected = {1'b0, vec_q[VW-1:WIDTH+1]} + {1'b0, vec_q[WIDTH:1]}
             + {{WIDTH{1'b0}}, vec_q[0]};
    mismatch = ({co, sum} != expected);
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    err_d       = err_q;
    fail_seen_d = fail_seen_q;
    fail_vec_d  = fail_vec_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d       = '0;
          err_d       = '0;
          fail_seen_d = 1'b0;
          fail_vec_d  = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          settle_d    = SW'(SETTLE);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (settle_q == SW'(1)) state_d = CHECK;
        else                    settle_d = settle_q - SW'(1);
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + CW'(1);
          if (!fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_vec_d  = vec_q;
          end
        end
        if (&vec_q) begin
          // Final verdict must include the last vector's own result.
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = !mismatch && (err_q == '0);
        end else begin
          vec_d    = vec_q + VW'(1);
          settle_d = SW'(SETTLE);
          state_d  = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      err_q       <= '0;
      fail_seen_q <= 1'b0;
      fail_vec_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      err_q       <= err_d;
      fail_seen_q <= fail_seen_d;
      fail_vec_q  <= fail_vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign a         = vec_q[VW-1:WIDTH+1];
  assign b         = vec_q[WIDTH:1];
  assign ci        = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_seen = fail_seen_q;
  assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_csa_bist.sv
// Directed bench for csa_bist: correct and faulty adder models, ignored restart,
// mid-sweep reset, and a second small instance (WIDTH=2, SETTLE=1).
module tb_csa_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] a, b, sum;
  logic       ci, co;
  logic       busy, done, pass, fail_seen;
  logic [7:0] err_count;
  logic [6:0] fail_vec;

  logic       start2;
  logic [1:0] a2, b2, sum2;
  logic       ci2, co2;
  logic       busy2, done2, pass2, fail_seen2;
  logic [5:0] err_count2;
  logic [4:0] fail_vec2;

  int mode;   // 0 correct adder, 1 co stuck at 0, 2 sum[0] stuck at 1
  int checks;
  int errors;

  csa_bist #(.WIDTH(3), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .ci(ci), .sum(sum), .co(co),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_seen(fail_seen), .fail_vec(fail_vec)
  );

  csa_bist #(.WIDTH(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a(a2), .b(b2), .ci(ci2), .sum(sum2), .co(co2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .fail_seen(fail_seen2), .fail_vec(fail_vec2)
  );

  always_comb begin
    logic [3:0] r;
    r = {1'b0, a} + {1'b0, b} + {3'b0, ci};
    if (mode == 1) r[3] = 1'b0;
    if (mode == 2) r[0] = 1'b1;
    {co, sum} = r;
  end

  always_comb begin
    logic [2:0] r2;
    r2 = {1'b0, a2} + {1'b0, b2} + {2'b0, ci2};
    {co2, sum2} = r2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // Starts a sweep on the main instance; optional extra start pulse and reset.
  task automatic sweep(input string tag, input int pulse_at, input int reset_at,
                       output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 1000) begin
      start = (cyc == pulse_at);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (cyc == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (cyc == 2) check({tag, "_vec2"}, 32'({a, b, ci}), 32'd0);
      if (cyc == 3) check({tag, "_vec3"}, 32'({a, b, ci}), 32'd1);
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_vec"}, 32'({a, b, ci}), 32'd0);
        check({tag, "_rst_flags"}, 32'({busy, done, pass, fail_seen}), 32'd0);
        check({tag, "_rst_err"}, 32'(err_count), 32'd0);
        check({tag, "_rst_fvec"}, 32'(fail_vec), 32'd0);
        #3 rst_n = 1'b1;
        break;
      end
    end
  endtask

  task automatic sweep2(input string tag, output int cyc);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({tag, "_done_clr"}, 32'(done2), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    mode   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vec",   32'({a, b, ci}), 32'd0);
    check("reset_flags", 32'({busy, done, pass, fail_seen}), 32'd0);
    check("reset_err",   32'(err_count), 32'd0);
    check("reset_fvec",  32'(fail_vec), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct adder: 128 vectors * 3 cycles.
    sweep("ok", -1, -1, cyc);
    check("ok_cycles", 32'(cyc), 32'd384);
    check("ok_pass", 32'(pass), 32'd1);
    check("ok_err", 32'(err_count), 32'd0);
    check("ok_fseen", 32'(fail_seen), 32'd0);
    check("ok_busy", 32'(busy), 32'd0);
    check("ok_lastvec", 32'({a, b, ci}), 32'd127);
    repeat (5) @(posedge clk);
    #1 check("ok_hold", 32'({done, a, b, ci}), 32'h0FF);

    // co stuck at 0: every vector with a+b+ci >= 8 fails; first is a=0,b=7,ci=1.
    mode = 1;
    sweep("co0", -1, -1, cyc);
    check("co0_cycles", 32'(cyc), 32'd384);
    check("co0_pass", 32'(pass), 32'd0);
    check("co0_err", 32'(err_count), 32'd64);
    check("co0_fseen", 32'(fail_seen), 32'd1);
    check("co0_fvec", 32'(fail_vec), 32'd15);

    // sum[0] stuck at 1: every even sum fails, including vector 0.
    mode = 2;
    sweep("s0", -1, -1, cyc);
    check("s0_pass", 32'(pass), 32'd0);
    check("s0_err", 32'(err_count), 32'd64);
    check("s0_fseen", 32'(fail_seen), 32'd1);
    check("s0_fvec", 32'(fail_vec), 32'd0);

    // Start pulse at cycle 100 while busy is ignored.
    mode = 0;
    sweep("rest", 100, -1, cyc);
    check("rest_cycles", 32'(cyc), 32'd384);
    check("rest_pass", 32'(pass), 32'd1);
    check("rest_err", 32'(err_count), 32'd0);

    // Reset mid-sweep with errors already accumulated, then a clean fresh sweep.
    mode = 1;
    sweep("mrst", -1, 200, cyc);
    mode = 0;
    @(posedge clk); #1;
    sweep("fresh", -1, -1, cyc);
    check("fresh_cycles", 32'(cyc), 32'd384);
    check("fresh_pass", 32'(pass), 32'd1);
    check("fresh_err", 32'(err_count), 32'd0);
    check("fresh_fseen", 32'(fail_seen), 32'd0);

    // WIDTH=2, SETTLE=1: 32 vectors * 2 cycles, twice back to back.
    sweep2("w2a", cyc);
    check("w2a_cycles", 32'(cyc), 32'd64);
    check("w2a_pass", 32'(pass2), 32'd1);
    check("w2a_err", 32'(err_count2), 32'd0);
    check("w2a_lastvec", 32'({a2, b2, ci2}), 32'd31);
    sweep2("w2b", cyc);
    check("w2b_cycles", 32'(cyc), 32'd64);
    check("w2b_pass", 32'(pass2), 32'd1);
    check("w2b_busy", 32'(busy2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
